apb_master: RTL and testbench



---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_master.sv | 139 +++++++++++++
 tb/tb_apb_master.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states, the captured response and
// strobe-width helpers. The response struct fixes the data width used by apb_master.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 4;
    localparam int unsigned APB_DATA_WIDTH = 32;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    localparam int unsigned APB_STRB_WIDTH = strb_width(APB_DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS transfer
// on the bus, registered response out, with an optional PREADY wait-state timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr,
    input  logic [DATA_WIDTH-1:0]           cmd_wdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] cmd_strb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            rsp_timeout,
    output logic                            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [ADDR_WIDTH-1:0]           PADDR,
    output logic [strb_width(DATA_WIDTH)-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    input  logic [DATA_WIDTH-1:0]           PRDATA,
    input  logic                            PREADY,
    input  logic                            PSLVERR
);

    localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH);
    localparam int unsigned CNT_WIDTH  = (TIMEOUT < 3) ? 1 : $clog2(TIMEOUT);
    localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0]  pstrb_q, pstrb_d;
    logic                   pwrite_q, pwrite_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   rsp_valid_q, rsp_valid_d;
    apb_rsp_t               rsp_q, rsp_d;
    logic [CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;

    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        pwrite_d   = pwrite_q;
        rsp_d      = rsp_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d    = cmd_addr;
                    pwdata_d   = cmd_wdata;
                    pwrite_d   = cmd_write;
                    pstrb_d    = cmd_write ? cmd_strb : '0;
                    wait_cnt_d = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    rsp_d.rdata   = pwrite_q ? '0 : PRDATA;
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    state_d       = RESP;
                end else if (TIMEOUT_EN && wait_cnt_q == CNT_LAST) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    state_d       = RESP;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus controls are registered from the next state so they never glitch on decode.
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the datapath registers are reset as well, since their reset values are visible on ports.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE) && !PRESET;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PSTRB       = pstrb_q;
    assign PWDATA      = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a slave model in the stimulus task, expected
// responses queued at command handshake and checked by a separate monitor.
module tb_apb_master;
    import apb_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL, PENABLE, PWRITE;
    logic [3:0]  PADDR;
    logic [3:0]  PSTRB;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int       n_checks = 0;
    int       n_errors = 0;
    apb_rsp_t exp_q[$];
    apb_rsp_t mon_exp;

    apb_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PSTRB(PSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: sample away from the active edge and score every response handshake.
    always @(negedge PCLK) begin
        if (!PRESET && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: rdata 0x%08h err %0b timeout %0b with empty queue",
                         rsp_rdata, rsp_err, rsp_timeout);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, mon_exp.rdata);
                check("rsp_err", rsp_err, mon_exp.err);
                check("rsp_timeout", rsp_timeout, mon_exp.timeout);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // One full transfer; inputs are driven and bus outputs observed 1ns after each rising edge.
    task automatic do_xfer(input string tag, input logic wr, input logic [3:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int waits, input logic [31:0] rdata, input logic slverr,
                           input int bp, input int exp_acc, input logic [31:0] exp_rdata,
                           input logic exp_err, input logic exp_to);
        int       k;
        int       acc;
        logic     stable;
        apb_rsp_t e;
        e.rdata = exp_rdata;
        e.err = exp_err;
        e.timeout = exp_to;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
        cmd_valid = 1'b1;
        if (bp > 0) rsp_ready = 1'b0;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(posedge PCLK); #1;
            k++;
        end
        check({tag, " cmd_ready"}, cmd_ready, 1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        exp_q.push_back(e);
        check({tag, " setup_psel"}, PSEL, 1);
        check({tag, " setup_penable"}, PENABLE, 0);
        check({tag, " paddr"}, PADDR, addr);
        check({tag, " pwrite"}, PWRITE, wr);
        check({tag, " pstrb"}, PSTRB, wr ? strb : 4'h0);
        check({tag, " pwdata"}, PWDATA, wdata);
        @(posedge PCLK); #1;
        acc = 0;
        stable = 1'b1;
        while (PSEL && PENABLE && acc < 100) begin
            acc++;
            stable &= (PADDR == addr) && (PWRITE == wr) &&
                      (PSTRB == (wr ? strb : 4'h0)) && (PWDATA == wdata);
            PREADY  = (acc == waits + 1);
            PRDATA  = PREADY ? rdata : 32'hDEAD_BEEF;
            PSLVERR = PREADY ? slverr : 1'b1;
            @(posedge PCLK); #1;
        end
        PREADY = 1'b0;
        PSLVERR = 1'b0;
        PRDATA = '0;
        check({tag, " access_cycles"}, acc, exp_acc);
        check({tag, " bus_stable"}, stable, 1);
        check({tag, " resp_psel"}, PSEL, 0);
        check({tag, " resp_valid"}, rsp_valid, 1);
        for (int i = 0; i < bp; i++) begin
            check({tag, " bp_valid"}, rsp_valid, 1);
            check({tag, " bp_cmd_ready"}, cmd_ready, 0);
            check({tag, " bp_psel"}, PSEL, 0);
            check({tag, " bp_rdata"}, rsp_rdata, exp_rdata);
            check({tag, " bp_err"}, rsp_err, exp_err);
            check({tag, " bp_timeout"}, rsp_timeout, exp_to);
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        check({tag, " idle_cmd_ready"}, cmd_ready, 1);
        check({tag, " idle_rsp_valid"}, rsp_valid, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " psel"}, PSEL, 0);
        check({tag, " penable"}, PENABLE, 0);
        check({tag, " pwrite"}, PWRITE, 0);
        check({tag, " paddr"}, PADDR, 0);
        check({tag, " pwdata"}, PWDATA, 0);
        check({tag, " pstrb"}, PSTRB, 0);
        check({tag, " rsp_valid"}, rsp_valid, 0);
        check({tag, " rsp_rdata"}, rsp_rdata, 0);
        check({tag, " rsp_err"}, rsp_err, 0);
        check({tag, " rsp_timeout"}, rsp_timeout, 0);
        check({tag, " cmd_ready"}, cmd_ready, 0);
    endtask

    initial begin
        repeat (3) @(posedge PCLK);
        #1;
        check_reset_values("reset");
        PRESET = 1'b0;
        #1;
        check("reset_release cmd_ready", cmd_ready, 1);
        @(posedge PCLK); #1;

        //       tag       wr  addr  wdata          strb  waits rdata          serr bp acc exp_rdata      err to
        do_xfer("wr0",     1, 4'h2, 32'hA5A5_0F0F, 4'hF, 0,    32'hFFFF_FFFF, 0,   0, 1,  32'h0,         0,  0);
        do_xfer("rd_wait", 0, 4'h3, 32'h7777_0001, 4'hF, 3,    32'h1234_5678, 0,   0, 4,  32'h1234_5678, 0,  0);
        do_xfer("wr_err",  1, 4'h5, 32'h1122_3344, 4'h5, 1,    32'hFFFF_FFFF, 1,   0, 2,  32'h0,         1,  0);
        do_xfer("rd_to",   0, 4'h7, 32'h0,         4'hF, 1000, 32'h5555_5555, 0,   0, 16, 32'h0,         1,  1);
        do_xfer("rd_ok",   0, 4'h1, 32'h0,         4'h0, 0,    32'hCAFE_F00D, 0,   0, 1,  32'hCAFE_F00D, 0,  0);
        do_xfer("rd_bp",   0, 4'hF, 32'h0,         4'hF, 2,    32'h0BAD_C0DE, 1,   5, 3,  32'h0BAD_C0DE, 1,  0);
        do_xfer("wr_c",    1, 4'h8, 32'hFFFF_0000, 4'hC, 0,    32'h0,         0,   0, 1,  32'h0,         0,  0);

        // Reset in the middle of an ACCESS phase; no response is expected.
        cmd_write = 1'b1;
        cmd_addr  = 4'h9;
        cmd_wdata = 32'h5555_AAAA;
        cmd_strb  = 4'h3;
        cmd_valid = 1'b1;
        check("midrst cmd_ready", cmd_ready, 1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        check("midrst in_access", PENABLE, 1);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        check_reset_values("midrst");
        PRESET = 1'b0;
        #1;
        check("midrst release cmd_ready", cmd_ready, 1);
        @(posedge PCLK); #1;

        do_xfer("wr_post", 1, 4'h4, 32'h0102_0304, 4'hF, 0,    32'h0,         0,   0, 1,  32'h0,         0,  0);

        repeat (2) @(posedge PCLK);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
